cic_interp: RTL and testbench

CIC interpolator: N-stage comb section at the low (input) rate, zero-stuffing upsampler by a runtime ratio R, and N-stage integrator section at the high (output) rate. It is the transmit-side counterpart of the CIC decimator in the DSP chain: it takes one low-rate sample per R enabled clocks and delivers one high-rate sample per enabled clock. It feeds DACs and upconversion paths.

---
 rtl/cic_interp.sv | 118 +++++++++++
 tb/tb_cic_interp.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_interp.sv
// CIC interpolator: N comb stages at the input rate, zero-stuffing by R = rate_i+1,
// N integrator stages at the output rate. Define CIC_INTERP_ROUND_EN for round-half-up output.
module cic_interp #(
  parameter int DATAIN_WIDTH  = 16,
  parameter int DATAOUT_WIDTH = DATAIN_WIDTH,
  parameter int M             = 2,
  parameter int N             = 5,
  parameter int MAXRATE       = 64,
  parameter int bitgrowth     = 29,
  parameter int RATE_WIDTH    = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [DATAIN_WIDTH-1:0]  data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [RATE_WIDTH-1:0]    rate_i,
  output logic [DATAOUT_WIDTH-1:0] data_o,
  output logic                     val_o,
  output logic                     underflow_o
);
  localparam int W  = DATAIN_WIDTH + bitgrowth;
  localparam int PW = $clog2(MAXRATE);

  typedef logic [W-1:0] word_t;

  logic [PW-1:0]            phase_q, phase_d;
  logic [RATE_WIDTH-1:0]    rate_q, rate_d;
  word_t                    comb_q [N];
  word_t                    comb_d [N];
  word_t                    dly_q  [N][M];
  word_t                    dly_d  [N][M];
  word_t                    integ_q [N];
  word_t                    integ_d [N];
  logic [DATAOUT_WIDTH-1:0] data_q, data_d;
  logic                     val_q, val_d;
  logic                     unf_q, unf_d;

  logic  slot;
  word_t x;
  word_t u;
  word_t out_full;

`ifdef CIC_INTERP_ROUND_EN
  localparam word_t HALF = word_t'(1) << (W - DATAOUT_WIDTH - 1);
  assign out_full = integ_q[N-1] + HALF;
`else
  assign out_full = integ_q[N-1];
`endif

  always_comb begin
    slot    = en_i && (phase_q == '0);
    x       = valid_i ? {{bitgrowth{data_i[DATAIN_WIDTH-1]}}, data_i} : '0;
    u       = slot ? comb_q[N-1] : '0;
    phase_d = phase_q;
    rate_d  = rate_q;
    unf_d   = unf_q;
    comb_d  = comb_q;
    dly_d   = dly_q;
    integ_d = integ_q;
    data_d  = data_q;
    val_d   = en_i;

    if (slot) begin
      // Ratio is latched once per period; later rate_i changes wait for the next slot.
      rate_d  = rate_i;
      phase_d = (rate_i == '0) ? '0 : PW'(1);
      if (!valid_i) unf_d = 1'b1;
      comb_d[0]   = x - dly_q[0][M-1];
      dly_d[0][0] = x;
      for (int unsigned m = 1; m < M; m++) dly_d[0][m] = dly_q[0][m-1];
      for (int unsigned i = 1; i < N; i++) begin
        comb_d[i]   = comb_q[i-1] - dly_q[i][M-1];
        dly_d[i][0] = comb_q[i-1];
        for (int unsigned m = 1; m < M; m++) dly_d[i][m] = dly_q[i][m-1];
      end
    end else if (en_i) begin
      phase_d = (phase_q == rate_q) ? '0 : phase_q + 1'b1;
    end

    if (en_i) begin
      integ_d[0] = integ_q[0] + u;
      for (int unsigned i = 1; i < N; i++) integ_d[i] = integ_q[i] + integ_q[i-1];
      data_d = out_full[W-1 -: DATAOUT_WIDTH];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q <= '0;
      rate_q  <= '0;
      data_q  <= '0;
      val_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        comb_q[i]  <= '0;
        integ_q[i] <= '0;
        for (int unsigned m = 0; m < M; m++) dly_q[i][m] <= '0;
      end
    end else begin
      phase_q <= phase_d;
      rate_q  <= rate_d;
      data_q  <= data_d;
      val_q   <= val_d;
      unf_q   <= unf_d;
      comb_q  <= comb_d;
      dly_q   <= dly_d;
      integ_q <= integ_d;
    end
  end

  assign ready_o     = (phase_q == '0);
  assign data_o      = data_q;
  assign val_o       = val_q;
  assign underflow_o = unf_q;

endmodule

// File: tb/tb_cic_interp.sv
// Bench for cic_interp: direct-form FIR reference ((1-z^-RM)/(1-z^-1))^N on the zero-stuffed
// input, plus hand-computed steady-state DC vectors and directed reset/ratio/underflow/gap sequences.
module tb_cic_interp;
  localparam int DW = 16;
  localparam int NS = 5;
  localparam int MD = 2;
  localparam int RW = 6;
  localparam int SH = 29;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          valid = 1'b0;
  logic [DW-1:0] din = '0;
  logic [RW-1:0] rate = '0;
  logic          ready, val, unf;
  logic [DW-1:0] dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cic_interp #(
    .DATAIN_WIDTH (16),
    .DATAOUT_WIDTH(16),
    .M            (2),
    .N            (5),
    .MAXRATE      (64),
    .bitgrowth    (29),
    .RATE_WIDTH   (6)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .data_i     (din),
    .valid_i    (valid),
    .ready_o    (ready),
    .rate_i     (rate),
    .data_o     (dout),
    .val_o      (val),
    .underflow_o(unf)
  );

  // Reference model state
  longint        h    [0:1023];
  longint        htmp [0:1023];
  longint        xs   [0:4095];
  int            hlen;
  int            R;
  int            t_en;
  logic          unf_exp;
  logic [DW-1:0] exp_out;

  typedef struct {
    int                 r;
    logic signed [15:0] din;
    logic signed [15:0] exp;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at t_en=%0d: got %0d expected %0d", name, t_en, act, req);
    end
  endtask

  task automatic build_h(input int r);
    int  L;
    longint acc;
    L = r * MD;
    for (int i = 0; i < 1024; i++) h[i] = 0;
    h[0] = 1;
    hlen = 1;
    repeat (NS) begin
      for (int i = 0; i < hlen + L - 1; i++) begin
        acc = 0;
        for (int j = 0; j < L; j++)
          if (i - j >= 0 && i - j < hlen) acc += h[i-j];
        htmp[i] = acc;
      end
      hlen = hlen + L - 1;
      for (int i = 0; i < hlen; i++) h[i] = htmp[i];
    end
  endtask

  // Full-precision output after enabled edge t (total latency N + N*R enabled cycles).
  function automatic longint model_full(input int t);
    longint acc;
    int     n;
    int     p;
    acc = 0;
    n = t - NS - NS * R;
    for (int j = 0; j < hlen; j++) begin
      p = n - j;
      if (p >= 0 && (p % R) == 0) acc += h[j] * xs[p / R];
    end
    return acc;
  endfunction

  function automatic logic [DW-1:0] quantize(input longint y);
    longint q;
    longint yy;
    yy = y;
`ifdef CIC_INTERP_ROUND_EN
    yy = yy + (longint'(1) <<< (SH - 1));
`endif
    q = yy >>> SH;
    return q[DW-1:0];
  endfunction

  task automatic model_restart(input int r);
    R       = r;
    t_en    = 0;
    unf_exp = 1'b0;
    exp_out = '0;
    build_h(r);
  endtask

  task automatic do_reset(input int r);
    en    = 1'b0;
    valid = 1'b0;
    din   = '0;
    rate  = RW'(r - 1);
    model_restart(r);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: checks the slot schedule, drives inputs, then checks outputs against the model.
  task automatic cycle(input logic e, input logic v, input logic [DW-1:0] d);
    logic slot_exp;
    slot_exp = ((t_en % R) == 0);
    chk("ready", ready, slot_exp);
    en    = e;
    valid = v;
    din   = d;
    if (e && slot_exp) begin
      xs[t_en / R] = v ? longint'($signed(d)) : 0;
      if (!v) unf_exp = 1'b1;
    end
    @(posedge clk);
    #1;
    if (e) begin
      exp_out = quantize(model_full(t_en));
      t_en++;
    end
    chk("val", val, e);
    chk("data", $signed(dout), $signed(exp_out));
    chk("underflow", unf, unf_exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{64, 16'sd16384, 16'sd16384};
    vecs[1] = '{64, -16'sd32768, -16'sd32768};
    vecs[2] = '{64, 16'sd32767, 16'sd32767};
    vecs[3] = '{32, 16'sd16384, 16'sd1024};
`ifdef CIC_INTERP_ROUND_EN
    vecs[4] = '{32, 16'sd8, 16'sd1};
    vecs[5] = '{32, -16'sd8, 16'sd0};
    vecs[7] = '{1, -16'sd32768, 16'sd0};
`else
    vecs[4] = '{32, 16'sd8, 16'sd0};
    vecs[5] = '{32, -16'sd8, -16'sd1};
    vecs[7] = '{1, -16'sd32768, -16'sd1};
`endif
    vecs[6] = '{8, -16'sd32768, -16'sd8};

    // Reset state while rst is held from time zero
    #1;
    chk("rst_data", $signed(dout), 0);
    chk("rst_val", val, 0);
    chk("rst_unf", unf, 0);
    chk("rst_ready", ready, 1);

    // DC steady state per ratio; transient is N*(M+1) slots
    for (int i = 0; i < 8; i++) begin
      do_reset(vecs[i].r);
      for (int c = 0; c < 18 * vecs[i].r; c++) cycle(1'b1, 1'b1, vecs[i].din);
      chk("dc_steady", $signed(dout), vecs[i].exp);
    end

    // Ratio change mid-period takes effect only at the next slot
    do_reset(32);
    for (int c = 0; c < 70; c++) cycle(1'b1, 1'b1, 16'sd16384);
    rate = RW'(3);
    for (int c = 70; c < 96; c++) cycle(1'b1, 1'b1, 16'sd16384);
    for (int c = 0; c < 16; c++) begin
      chk("ready_new_rate", ready, (c % 4) == 0);
      en = 1'b1;
      @(posedge clk);
      #1;
    end

    // Underflow: one slot without valid_i, with junk on data_i
    do_reset(4);
    for (int k = 0; k < 40; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (k == 10 && c == 0) cycle(1'b1, 1'b0, 16'sd12345);
        else cycle(1'b1, 1'b1, DW'(1000 * (k % 7) - 3000 + 77 * c));
      end
    end
    chk("unf_sticky", unf, 1);
    chk("unf_val_before_rst", val, 1);

    // Asynchronous reset mid-period, observed before any further clock edge
    en = 1'b1;
    valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
    end
    #3;
    rst = 1'b1;
    #1;
    chk("arst_data", $signed(dout), 0);
    chk("arst_val", val, 0);
    chk("arst_unf", unf, 0);
    chk("arst_ready", ready, 1);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_restart(4);
    for (int c = 0; c < 120; c++) cycle(1'b1, 1'b1, DW'(2500 - 40 * c));

    // Random 50% enable gaps with random data at R = 8
    do_reset(8);
    for (int c = 0; c < 700; c++) cycle(1'($urandom_range(0, 1)), 1'b1, DW'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
